// File: rtl/conv2_win_feed_pkg.sv
// Shared constants, state type and pixel offset helpers for the conv-2 window feeder.
package conv2_win_feed_pkg;

   localparam int DW       = 16;
   localparam int ROW_W    = 14;
   localparam int K        = 5;
   localparam int FM_WORDS = 18;

   localparam int WORD_W   = K * ROW_W * DW;
   localparam int WIN_W    = K * K * DW;
   localparam int WORD_AW  = $clog2(WORD_W);
   localparam int WIN_AW   = $clog2(WIN_W);

   localparam int ROW_CW   = 5;
   localparam int COL_CW   = 4;
   localparam int LAST_COL = ROW_W - K;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_STREAM,
      ST_DRAIN
   } feed_state_t;

   // LSB of pixel (r,c) inside a feature-map word; row 0 / col 0 sit in the MSBs
   function automatic int pix_lsb(input int r, input int c);
      return ((K - 1 - r) * ROW_W + (ROW_W - 1 - c)) * DW;
   endfunction

   // LSB of window position (r,k); position (0,0) sits in the MSBs
   function automatic int win_lsb(input int r, input int k);
      return (K * K - 1 - (r * K + k)) * DW;
   endfunction

endpackage

// File: rtl/conv2_win_feed_if.sv
// Window stream from the feeder to the conv-2 MAC array (valid/ready).
interface conv2_win_feed_if;
   import conv2_win_feed_pkg::*;

   logic                win_valid;
   logic                win_ready;
   logic [WIN_W-1:0]    win_data;
   logic [ROW_CW-1:0]   win_row;
   logic [COL_CW-1:0]   win_col;
   logic                win_last;

   modport master (
      output win_valid,
      output win_data,
      output win_row,
      output win_col,
      output win_last,
      input  win_ready
   );

   modport slave (
      input  win_valid,
      input  win_data,
      input  win_row,
      input  win_col,
      input  win_last,
      output win_ready
   );

endinterface

// File: rtl/conv2_win_feed_win_mux5x5.sv
// Combinational K x K window select out of one feature-map word, left edge at col.
module conv2_win_feed_win_mux5x5
   import conv2_win_feed_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [COL_CW-1:0] col,
   output logic [WIN_W-1:0]  win
);

   // gather pixel (r, col+k) into window slot (r,k); out-of-row columns read as zero
   always_comb begin
      win = '0;
      for (int r = 0; r < K; r++) begin
         for (int k = 0; k < K; k++) begin
            if (int'(col) + k < ROW_W) begin
               win[WIN_AW'(win_lsb(r, k)) +: DW] =
                  word[WORD_AW'(pix_lsb(r, int'(col) + k)) +: DW];
            end
         end
      end
   end

endmodule

// File: rtl/conv2_win_feed.sv
// conv2_win_feed: reads pooled feature-map words and streams 5x5 windows to conv-2.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for start; no reads, no windows
//   ST_FILL   | word 0 read issued, waiting for it to land in the active buffer
//   ST_STREAM | windows streaming; next word prefetched into the shadow buffer
//   ST_DRAIN  | last word active, no more reads; ends on accept of final window
//
// Each load of the active buffer issues the read for the following word, so
// there is never more than one read in flight and the shadow is always empty
// when that read returns.
module conv2_win_feed
   import conv2_win_feed_pkg::*;
#(
   parameter int NUM_WORDS = FM_WORDS,
   parameter int ADDR_W    = 5,
   parameter int BRAM_LAT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              fm_rd_en,
   output logic [ADDR_W-1:0] fm_rd_addr,
   input  logic [WORD_W-1:0] fm_rd_data,
   conv2_win_feed_if.master  win,
   output logic              busy,
   output logic              done
);

   localparam logic [ROW_CW-1:0] LAST_ROW = ROW_CW'(NUM_WORDS - 1);
   localparam logic [COL_CW-1:0] COL_END  = COL_CW'(LAST_COL);

   feed_state_t         state, state_nx;

   logic [WORD_W-1:0]   act_buf;
   logic [WORD_W-1:0]   shd_buf;
   logic                shd_vld;
   logic [BRAM_LAT-1:0] rd_pipe;

   logic                win_valid;
   logic [ROW_CW-1:0]   row;
   logic [COL_CW-1:0]   col;
   logic [WIN_W-1:0]    win_sel;

   logic                in_fill;
   logic                in_stream;
   logic                in_drain;
   logic                start_ok;

   logic                cap;
   logic                acc;
   logic                word_end;
   logic                load_act;
   logic [WORD_W-1:0]   src_word;
   logic [ROW_CW-1:0]   row_load;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (start_ok) state_nx = ST_FILL;
         end
         ST_FILL: begin
            if (load_act) state_nx = (row_load == LAST_ROW) ? ST_DRAIN : ST_STREAM;
         end
         ST_STREAM: begin
            if (load_act && (row_load == LAST_ROW)) state_nx = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (word_end) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // state-derived controls; start is ignored during the done cycle since busy is still high
   always_comb begin
      in_fill   = 1'b0;
      in_stream = 1'b0;
      in_drain  = 1'b0;
      start_ok  = 1'b0;
      case (state)
         ST_IDLE:   start_ok  = start && !done;
         ST_FILL:   in_fill   = 1'b1;
         ST_STREAM: in_stream = 1'b1;
         ST_DRAIN:  in_drain  = 1'b1;
         default:   ;
      endcase
   end

   // handshake and active-buffer load decisions
   always_comb begin
      cap      = rd_pipe[BRAM_LAT-1];
      acc      = win_valid && win.win_ready;
      word_end = acc && (col == COL_END);
      src_word = shd_vld ? shd_buf : fm_rd_data;
      row_load = in_fill ? ROW_CW'(0) : row + 1'b1;
      load_act = 1'b0;
      if (in_fill) begin
         load_act = cap;
      end else if (in_stream) begin
         load_act = (word_end || !win_valid) && (shd_vld || cap);
      end
   end

   // read-return tracker: marks the cycle fm_rd_data carries the requested word
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_pipe <= '0;
      end else begin
         rd_pipe[0] <= fm_rd_en;
         for (int i = 1; i < BRAM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   // buffers, counters and read issue
   always_ff @(posedge clk) begin
      if (rst) begin
         fm_rd_en   <= 1'b0;
         fm_rd_addr <= '0;
         act_buf    <= '0;
         shd_buf    <= '0;
         shd_vld    <= 1'b0;
         win_valid  <= 1'b0;
         row        <= '0;
         col        <= '0;
         done       <= 1'b0;
      end else begin
         fm_rd_en <= 1'b0;
         done     <= 1'b0;
         if (start_ok) begin
            fm_rd_en   <= 1'b1;
            fm_rd_addr <= '0;
            shd_vld    <= 1'b0;
            row        <= '0;
            col        <= '0;
         end
         if (load_act) begin
            act_buf   <= src_word;
            shd_vld   <= 1'b0;
            win_valid <= 1'b1;
            row       <= row_load;
            col       <= '0;
            if (row_load != LAST_ROW) begin
               fm_rd_en   <= 1'b1;
               fm_rd_addr <= fm_rd_addr + 1'b1;
            end
         end else begin
            if (cap) begin
               shd_buf <= fm_rd_data;
               shd_vld <= 1'b1;
            end
            if (word_end) begin
               win_valid <= 1'b0;
               if (in_drain) done <= 1'b1;
            end else if (acc) begin
               col <= col + 1'b1;
            end
         end
      end
   end

   conv2_win_feed_win_mux5x5 u_mux (
      .word (act_buf),
      .col  (col),
      .win  (win_sel)
   );

   assign win.win_valid = win_valid;
   assign win.win_data  = win_sel;
   assign win.win_row   = row;
   assign win.win_col   = col;
   assign win.win_last  = in_drain && win_valid && (row == LAST_ROW) && (col == COL_END);
   assign busy          = (state != ST_IDLE) || done;

endmodule

// File: tb/tb_conv2_win_feed.sv
// Bench for conv2_win_feed: three instances (BRAM_LAT 2, 1, 8), each with its own BRAM model.
module tb_conv2_win_feed;
   import conv2_win_feed_pkg::*;

   localparam int NI     = 3;
   localparam int NWORDS = 18;
   localparam int NWIN   = NWORDS * 10;

   logic clk = 1'b0;
   logic rst;
   int   salt = 0;
   int   checks = 0;
   int   errors = 0;

   logic             start_s  [NI];
   logic             ready_s  [NI];
   logic             rd_en_s  [NI];
   logic [4:0]       rd_addr_s[NI];
   logic [WORD_W-1:0] rd_data_s[NI];
   logic             valid_s  [NI];
   logic [WIN_W-1:0] data_s   [NI];
   logic [4:0]       row_s    [NI];
   logic [3:0]       col_s    [NI];
   logic             last_s   [NI];
   logic             busy_s   [NI];
   logic             done_s   [NI];
   int               rdcnt_s  [NI];

   always #5 clk = ~clk;

   function automatic int lat_of(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 8);
   endfunction

   function automatic logic [15:0] pix(input int n, input int r, input int c);
      return 16'(n * 256 + r * 16 + c + salt);
   endfunction

   // word built raster-order, first pixel ends up in the MSBs
   function automatic logic [WORD_W-1:0] make_word(input int n);
      logic [WORD_W-1:0] w;
      w = '0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 14; c++)
            w = {w[WORD_W-17:0], pix(n, r, c)};
      return w;
   endfunction

   function automatic logic [WIN_W-1:0] exp_win(input int n, input int c0);
      logic [WIN_W-1:0] w;
      w = '0;
      for (int r = 0; r < 5; r++)
         for (int k = 0; k < 5; k++)
            w = {w[WIN_W-17:0], pix(n, r, c0 + k)};
      return w;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 8);
      conv2_win_feed_if wif ();
      logic [WORD_W-1:0] dly [LAT];
      int rdcnt = 0;

      assign wif.win_ready = ready_s[g];

      conv2_win_feed #(.NUM_WORDS(NWORDS), .ADDR_W(5), .BRAM_LAT(LAT)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .start      (start_s[g]),
         .fm_rd_en   (rd_en_s[g]),
         .fm_rd_addr (rd_addr_s[g]),
         .fm_rd_data (rd_data_s[g]),
         .win        (wif),
         .busy       (busy_s[g]),
         .done       (done_s[g])
      );

      assign valid_s[g] = wif.win_valid;
      assign data_s[g]  = wif.win_data;
      assign row_s[g]   = wif.win_row;
      assign col_s[g]   = wif.win_col;
      assign last_s[g]  = wif.win_last;

      // BRAM model: data appears LAT cycles after the enable cycle, zeros otherwise
      always @(posedge clk) begin
         dly[0] <= rd_en_s[g] ? make_word(int'(rd_addr_s[g])) : '0;
         for (int j = 1; j < LAT; j++) dly[j] <= dly[j-1];
         if (rd_en_s[g]) rdcnt <= rdcnt + 1;
      end
      assign rd_data_s[g] = dly[LAT-1];
      assign rdcnt_s[g]   = rdcnt;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input int i, input string pfx);
      chk({pfx, " rd_en"},   rd_en_s[i],   0);
      chk({pfx, " rd_addr"}, rd_addr_s[i], 0);
      chk({pfx, " valid"},   valid_s[i],   0);
      chk_w({pfx, " data"},  data_s[i],    '0);
      chk({pfx, " row"},     row_s[i],     0);
      chk({pfx, " col"},     col_s[i],     0);
      chk({pfx, " last"},    last_s[i],    0);
      chk({pfx, " busy"},    busy_s[i],    0);
      chk({pfx, " done"},    done_s[i],    0);
   endtask

   // one run on instance i; rnd selects random backpressure, abort_at resets after that many accepts
   task automatic run(input int i, input bit rnd, input int abort_at, input int dup_start_at);
      int t, idx, first_v, last_c, done_c, rd0, stall_left, quiet, nd;
      bit prev_stall, long_done, rdy, fin, aborted;
      logic [WIN_W-1:0] p_data;
      logic [4:0] p_row;
      logic [3:0] p_col;
      logic p_last;
      idx = 0; first_v = -1; last_c = -1; done_c = -1; stall_left = 0;
      prev_stall = 0; long_done = 0; fin = 0; aborted = 0;
      p_data = '0; p_row = '0; p_col = '0; p_last = 0;
      @(negedge clk);
      rd0 = rdcnt_s[i];
      start_s[i] = 1'b1;
      ready_s[i] = 1'b0;
      t = 0;
      while (!fin && t < 4000) begin
         @(negedge clk);
         t++;
         start_s[i] = (t == dup_start_at);
         if (t == 1) begin
            chk("first rd_en", rd_en_s[i], 1);
            chk("first rd_addr", rd_addr_s[i], 0);
            chk("busy after start", busy_s[i], 1);
         end
         if (prev_stall) begin
            chk("stall valid held", valid_s[i], 1);
            chk_w("stall data stable", data_s[i], p_data);
            chk("stall row stable", row_s[i], p_row);
            chk("stall col stable", col_s[i], p_col);
            chk("stall last stable", last_s[i], p_last);
         end
         if (valid_s[i] && first_v < 0) begin
            first_v = t;
            chk($sformatf("first valid cycle lat%0d", lat_of(i)), t, 2 + lat_of(i));
         end
         if (!rnd && first_v >= 0 && idx < NWIN)
            chk($sformatf("no bubble t%0d", t), valid_s[i], 1);
         if (done_s[i]) begin
            done_c = t;
            fin = 1;
            chk("busy in done cycle", busy_s[i], 1);
         end
         if (!rnd) rdy = 1'b1;
         else if (stall_left > 0) begin rdy = 1'b0; stall_left--; end
         else if (valid_s[i] && col_s[i] == 4'd9 && row_s[i] == 5'd4 && !long_done) begin
            long_done = 1; stall_left = 19; rdy = 1'b0;
         end
         else rdy = ($urandom_range(0, 3) != 0);
         ready_s[i] = rdy;
         prev_stall = valid_s[i] && !rdy;
         p_data = data_s[i]; p_row = row_s[i]; p_col = col_s[i]; p_last = last_s[i];
         if (valid_s[i] && rdy && !fin) begin
            chk_w($sformatf("win_data #%0d", idx), data_s[i], exp_win(idx / 10, idx % 10));
            chk($sformatf("win_row #%0d", idx), row_s[i], idx / 10);
            chk($sformatf("win_col #%0d", idx), col_s[i], idx % 10);
            chk($sformatf("win_last #%0d", idx), last_s[i], (idx == NWIN - 1));
            if (idx == 0 && salt == 0) chk("first MSB pixel", data_s[i][WIN_W-1 -: 16], 0);
            if (idx == 37 && salt == 0) chk("word3 col7 last pixel", data_s[i][15:0], 64'h34B);
            idx++;
            if (idx == NWIN) last_c = t;
            if (idx == abort_at) begin
               rst = 1'b1;
               aborted = 1;
               fin = 1;
            end
         end
      end
      ready_s[i] = 1'b0;
      start_s[i] = 1'b0;
      if (aborted) begin
         @(negedge clk);
         chk_zero(i, "after mid-run rst");
         rst = 1'b0;
         nd = 0;
         repeat (12) begin
            @(negedge clk);
            if (done_s[i]) nd++;
         end
         chk("no done after rst", nd, 0);
      end else begin
         chk("run completes", fin, 1);
         chk("window count", idx, NWIN);
         chk("done one after last", done_c, last_c + 1);
         chk("read count", rdcnt_s[i] - rd0, NWORDS);
         @(negedge clk);
         chk("busy low after done", busy_s[i], 0);
         quiet = 0;
         repeat (8) begin
            @(negedge clk);
            if (valid_s[i] || done_s[i] || rd_en_s[i]) quiet++;
         end
         chk("quiet after done", quiet, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NI; i++) begin
         start_s[i] = 1'b0;
         ready_s[i] = 1'b0;
      end
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) chk_zero(i, $sformatf("reset inst%0d", i));
      rst = 1'b0;

      // full run, ready high
      salt = 0;
      run(0, 1'b0, -1, -1);

      // random backpressure with a long stall at a word boundary
      salt = int'($urandom_range(1, 65535));
      run(0, 1'b1, -1, -1);

      // reset at window 57, then a clean restart from row 0 / addr 0
      salt = 0;
      run(0, 1'b0, 57, -1);
      run(0, 1'b0, -1, -1);

      // second start pulse mid-run is ignored
      run(0, 1'b0, -1, 50);

      // latency sweep
      run(1, 1'b0, -1, -1);
      run(2, 1'b0, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
